// File: rtl/mem_rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rob_pkg
//  Brief    : Shared types and default widths for the mem_rd_rob read
//             initiator / reorder buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_rob_pkg;

  // Per-entry life cycle: allocated -> awaiting memory -> data held -> free.
  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } rob_state_t;

  localparam int c_IDWIDTH_DEF = 4;
  localparam int c_AWIDTH_DEF  = 32;
  localparam int c_DWIDTH_DEF  = 32;

endpackage
`default_nettype wire

// File: rtl/mem_rob_entry.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rob_entry
//  Brief    : One reorder-buffer slot: FREE/WAIT/DONE state machine plus the
//             data register filled by the matching memory response.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rob_entry
  import mem_rob_pkg::*;
#(
  parameter int DWIDTH = c_DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              i_alloc,
  input  logic              i_rsp,
  input  logic              i_rsp_retire,
  input  logic [DWIDTH-1:0] i_rsp_data,
  input  logic              i_retire,
  output logic [1:0]        o_state,
  output logic [DWIDTH-1:0] o_data
);

  rob_state_t        r_state;
  logic [DWIDTH-1:0] r_data;

  // Slot state machine; a response consumed straight through to the client
  // frees the slot without ever latching the data.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state <= FREE;
      r_data  <= '0;
    end else begin
      case (r_state)
        FREE: begin
          if (i_alloc) r_state <= WAIT;
        end
        WAIT: begin
          if (i_rsp) begin
            if (i_rsp_retire) begin
              r_state <= FREE;
            end else begin
              r_state <= DONE;
              r_data  <= i_rsp_data;
            end
          end
        end
        DONE: begin
          if (i_retire) r_state <= FREE;
        end
        default: r_state <= FREE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/mem_rd_rob.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rd_rob
//  Brief    : Read-side initiator with reorder buffer. Allocates an ID per
//             in-order client read, issues it to memory, accepts responses in
//             any order and returns data to the client in request order.
//  Options  : ROB_RSP_BYPASS_EN - forward a response for the head entry to
//             the client in the same cycle it arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rd_rob
  import mem_rob_pkg::*;
#(
  parameter int IDWIDTH = c_IDWIDTH_DEF,
  parameter int AWIDTH  = c_AWIDTH_DEF,
  parameter int DWIDTH  = c_DWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               cl_req_val,
  input  logic [AWIDTH-1:0]  cl_req_addr,
  output logic               cl_req_rdy,
  output logic               cl_rsp_val,
  output logic [DWIDTH-1:0]  cl_rsp_data,
  input  logic               cl_rsp_rdy,
  output logic               mem_req_val,
  output logic [AWIDTH-1:0]  mem_req_addr,
  output logic [IDWIDTH-1:0] mem_req_ID,
  input  logic               mem_rsp_val,
  input  logic [IDWIDTH-1:0] mem_rsp_ID,
  input  logic [DWIDTH-1:0]  mem_rsp_data,
  output logic               err_unexp
);

  localparam int                 c_DEPTH     = 2 ** IDWIDTH;
  localparam logic [IDWIDTH:0]   c_DEPTH_CNT = (IDWIDTH+1)'(c_DEPTH);

  logic [IDWIDTH-1:0] r_head;
  logic [IDWIDTH-1:0] r_tail;
  logic [IDWIDTH:0]   r_count;

  logic               r_mem_req_val;
  logic [AWIDTH-1:0]  r_mem_req_addr;
  logic [IDWIDTH-1:0] r_mem_req_id;
  logic               r_err_unexp;

  logic [1:0]         w_state [c_DEPTH];
  logic [DWIDTH-1:0]  w_data  [c_DEPTH];

  logic w_accept;
  logic w_retire;
  logic w_rsp_hit;
  logic w_rsp_unexp;
  logic w_bypass;

  // Full flag depends only on the occupancy register, never on cl_rsp_rdy.
  assign cl_req_rdy  = (r_count != c_DEPTH_CNT);
  assign w_accept    = cl_req_val && cl_req_rdy;

  assign w_rsp_hit   = mem_rsp_val && (w_state[mem_rsp_ID] == WAIT);
  assign w_rsp_unexp = mem_rsp_val && (w_state[mem_rsp_ID] != WAIT);

`ifdef ROB_RSP_BYPASS_EN
  assign w_bypass = w_rsp_hit && (mem_rsp_ID == r_head);
`else
  assign w_bypass = 1'b0;
`endif

  // Head data is presented either from the slot or straight off the bus.
  assign cl_rsp_val  = (w_state[r_head] == DONE) || w_bypass;
  assign cl_rsp_data = w_bypass ? mem_rsp_data : w_data[r_head];
  assign w_retire    = cl_rsp_val && cl_rsp_rdy;

  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_entry
    localparam logic [IDWIDTH-1:0] c_IDX = IDWIDTH'(gi);

    mem_rob_entry #(
      .DWIDTH (DWIDTH)
    ) u_entry (
      .clk          (clk),
      .rst_         (rst_),
      .i_alloc      (w_accept && (r_tail == c_IDX)),
      .i_rsp        (w_rsp_hit && (mem_rsp_ID == c_IDX)),
      .i_rsp_retire (w_bypass && cl_rsp_rdy),
      .i_rsp_data   (mem_rsp_data),
      .i_retire     (w_retire && (r_head == c_IDX)),
      .o_state      (w_state[gi]),
      .o_data       (w_data[gi])
    );
  end

  // Allocation/retire pointers and occupancy; concurrent accept and retire
  // leave the occupancy unchanged.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_retire) r_head <= r_head + 1'b1;
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle registered memory request stage carrying the allocated ID.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_mem_req_val  <= 1'b0;
      r_mem_req_addr <= '0;
      r_mem_req_id   <= '0;
    end else begin
      r_mem_req_val <= w_accept;
      if (w_accept) begin
        r_mem_req_addr <= cl_req_addr;
        r_mem_req_id   <= r_tail;
      end
    end
  end

  // Sticky flag for responses to IDs that are not awaiting data.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_err_unexp <= 1'b0;
    end else if (w_rsp_unexp) begin
      r_err_unexp <= 1'b1;
    end
  end

  assign mem_req_val  = r_mem_req_val;
  assign mem_req_addr = r_mem_req_addr;
  assign mem_req_ID   = r_mem_req_id;
  assign err_unexp    = r_err_unexp;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_rob.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_rd_rob
//  Brief    : Self-checking bench for mem_rd_rob (IDWIDTH=2, depth 4):
//             vector table, directed multi-cycle sequences and a randomized
//             run against an in-order queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rd_rob;

  localparam int IDW   = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

`ifdef ROB_RSP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_ = 1'b0;
  logic           cl_req_val = 1'b0;
  logic [AW-1:0]  cl_req_addr = '0;
  logic           cl_req_rdy;
  logic           cl_rsp_val;
  logic [DW-1:0]  cl_rsp_data;
  logic           cl_rsp_rdy = 1'b0;
  logic           mem_req_val;
  logic [AW-1:0]  mem_req_addr;
  logic [IDW-1:0] mem_req_ID;
  logic           mem_rsp_val = 1'b0;
  logic [IDW-1:0] mem_rsp_ID = '0;
  logic [DW-1:0]  mem_rsp_data = '0;
  logic           err_unexp;

  always #5 clk = ~clk;

  mem_rd_rob #(.IDWIDTH(IDW), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .cl_req_val   (cl_req_val),
    .cl_req_addr  (cl_req_addr),
    .cl_req_rdy   (cl_req_rdy),
    .cl_rsp_val   (cl_rsp_val),
    .cl_rsp_data  (cl_rsp_data),
    .cl_rsp_rdy   (cl_rsp_rdy),
    .mem_req_val  (mem_req_val),
    .mem_req_addr (mem_req_addr),
    .mem_req_ID   (mem_req_ID),
    .mem_rsp_val  (mem_rsp_val),
    .mem_rsp_ID   (mem_rsp_ID),
    .mem_rsp_data (mem_rsp_data),
    .err_unexp    (err_unexp)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] got[$];

  typedef struct {
    logic           req_val;
    logic [AW-1:0]  req_addr;
    logic           rsp_rdy;
    logic           mrsp_val;
    logic [IDW-1:0] mrsp_id;
    logic [DW-1:0]  mrsp_data;
    logic           e_req_rdy;
    logic           e_rsp_val;
    logic [DW-1:0]  e_rsp_data;
    logic           e_mreq_val;
    logic [IDW-1:0] e_mreq_id;
    logic [AW-1:0]  e_mreq_addr;
    logic           e_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    cl_req_val   = 1'b0;
    cl_req_addr  = '0;
    mem_rsp_val  = 1'b0;
    mem_rsp_ID   = '0;
    mem_rsp_data = '0;
  endtask

  // Move to the input-drive window just after the next rising edge.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse with reset-value checks; returns in a drive window.
  task automatic do_reset(input string tag);
    clr();
    cl_rsp_rdy = 1'b0;
    #1 rst_ = 1'b1;
    #1;
    chk({tag, "_rst_req_rdy"},  cl_req_rdy,   1);
    chk({tag, "_rst_rsp_val"},  cl_rsp_val,   0);
    chk({tag, "_rst_rsp_data"}, cl_rsp_data,  0);
    chk({tag, "_rst_mreq_val"}, mem_req_val,  0);
    chk({tag, "_rst_mreq_adr"}, mem_req_addr, 0);
    chk({tag, "_rst_mreq_id"},  mem_req_ID,   0);
    chk({tag, "_rst_err"},      err_unexp,    0);
    to_drive();
    rst_ = 1'b0;
  endtask

  // Keep consuming until 'want' items have been collected or the budget ends.
  task automatic collect(input int want, input int budget);
    int cyc;
    cyc = 0;
    cl_rsp_rdy = 1'b1;
    while (got.size() < want && cyc < budget) begin
      @(negedge clk);
      if (cl_rsp_val && cl_rsp_rdy) got.push_back(cl_rsp_data);
      to_drive();
      clr();
      cyc++;
    end
    chk("collect_count", got.size(), want);
  endtask

  // Random-run reference model: ordered list of outstanding IDs.
  int            oq[$];
  bit            m_out  [DEPTH];
  bit            m_done [DEPTH];
  logic [DW-1:0] m_dat  [DEPTH];
  int            m_next;
  bit            m_err;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected completion", n_vec);
    $fatal(1);
  end

  initial begin
    // ---------------- table: single read and unexpected response ----------
    //          rv    addr         rr    mv    id     data          rdy   val   rdata          mv    mid    maddr         err
    tbl[0]  = '{1'b1, 32'h100,    1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 2'd0, 32'h100,      1'b0};
    tbl[2]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
`ifdef ROB_RSP_BYPASS_EN
    tbl[5]  = '{1'b0, 32'h0,      1'b1, 1'b1, 2'd0, 32'hAA,       1'b1, 1'b1, 32'hAA,        1'b0, 2'd0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
`else
    tbl[5]  = '{1'b0, 32'h0,      1'b1, 1'b1, 2'd0, 32'hAA,       1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 32'hAA,        1'b0, 2'd0, 32'h0,        1'b0};
`endif
    tbl[7]  = '{1'b0, 32'h0,      1'b1, 1'b1, 2'd2, 32'h33,       1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'h0,      1'b1, 1'b1, 2'd0, 32'h77,       1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h0,      1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b0, 2'd0, 32'h0,        1'b1};

    do_reset("tbl");
    for (int i = 0; i < 11; i++) begin
      cl_req_val   = tbl[i].req_val;
      cl_req_addr  = tbl[i].req_addr;
      cl_rsp_rdy   = tbl[i].rsp_rdy;
      mem_rsp_val  = tbl[i].mrsp_val;
      mem_rsp_ID   = tbl[i].mrsp_id;
      mem_rsp_data = tbl[i].mrsp_data;
      @(negedge clk);
      chk("tbl_req_rdy",  cl_req_rdy,  tbl[i].e_req_rdy);
      chk("tbl_rsp_val",  cl_rsp_val,  tbl[i].e_rsp_val);
      if (tbl[i].e_rsp_val) chk("tbl_rsp_data", cl_rsp_data, tbl[i].e_rsp_data);
      chk("tbl_mreq_val", mem_req_val, tbl[i].e_mreq_val);
      if (tbl[i].e_mreq_val) begin
        chk("tbl_mreq_id",   mem_req_ID,   tbl[i].e_mreq_id);
        chk("tbl_mreq_addr", mem_req_addr, tbl[i].e_mreq_addr);
      end
      chk("tbl_err", err_unexp, tbl[i].e_err);
      to_drive();
    end

    // ---------------- out-of-order completion ------------------------------
    do_reset("ooo");
    cl_rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cl_req_val  = 1'b1;
      cl_req_addr = 32'h1000 + 32'(i * 4);
      @(negedge clk);
      chk("ooo_req_rdy", cl_req_rdy, 1);
      if (i > 0) begin
        chk("ooo_mreq_val", mem_req_val, 1);
        chk("ooo_mreq_id",  mem_req_ID,  i - 1);
      end
      to_drive();
    end
    clr();
    @(negedge clk);
    chk("ooo_mreq_id3", mem_req_ID, 3);
    chk("ooo_full", cl_req_rdy, 0);
    to_drive();
    got.delete();
    begin
      int order [4];
      order = '{3, 1, 0, 2};
      for (int k = 0; k < 4; k++) begin
        mem_rsp_val  = 1'b1;
        mem_rsp_ID   = IDW'(order[k]);
        mem_rsp_data = 32'hD000 + 32'(order[k]);
        @(negedge clk);
        if (k < 2) chk("ooo_hold_val", cl_rsp_val, 0);
        if (k == 2) chk("ooo_head_val", cl_rsp_val, BYP);
        if (cl_rsp_val && cl_rsp_rdy) got.push_back(cl_rsp_data);
        to_drive();
        clr();
      end
    end
    collect(4, 20);
    for (int j = 0; j < 4; j++) begin
      if (j < got.size()) chk("ooo_order", got[j], 32'hD000 + 32'(j));
    end

    // ---------------- full / backpressure / wrap / reset mid-op ------------
    do_reset("full");
    cl_rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cl_req_val  = 1'b1;
      cl_req_addr = 32'h200 + 32'(i * 4);
      @(negedge clk);
      chk("full_fill_rdy", cl_req_rdy, 1);
      to_drive();
    end
    clr();
    mem_rsp_val = 1'b1; mem_rsp_ID = 2'd0; mem_rsp_data = 32'h55;
    @(negedge clk);
    chk("full_req_rdy",  cl_req_rdy, 0);
    chk("full_mreq_id3", mem_req_ID, 3);
    to_drive();
    clr();
    mem_rsp_val = 1'b1; mem_rsp_ID = 2'd1; mem_rsp_data = 32'h66;
    @(negedge clk);
    to_drive();
    clr();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_val",     cl_rsp_val,  1);
      chk("bp_data",    cl_rsp_data, 32'h55);
      chk("bp_req_rdy", cl_req_rdy,  0);
      to_drive();
    end
    cl_rsp_rdy = 1'b1;
    @(negedge clk);
    chk("ret_val",     cl_rsp_val,  1);
    chk("ret_data",    cl_rsp_data, 32'h55);
    chk("ret_req_rdy", cl_req_rdy,  0);
    to_drive();
    cl_req_val = 1'b1; cl_req_addr = 32'h300;
    @(negedge clk);
    chk("wrap_req_rdy", cl_req_rdy,  1);
    chk("sim_rsp_val",  cl_rsp_val,  1);
    chk("sim_rsp_data", cl_rsp_data, 32'h66);
    to_drive();
    cl_rsp_rdy = 1'b0;
    cl_req_val = 1'b1; cl_req_addr = 32'h304;
    @(negedge clk);
    chk("wrap_mreq_val",  mem_req_val,  1);
    chk("wrap_mreq_id",   mem_req_ID,   0);
    chk("wrap_mreq_addr", mem_req_addr, 32'h300);
    chk("sim_req_rdy",    cl_req_rdy,   1);
    to_drive();
    clr();
    @(negedge clk);
    chk("refill_req_rdy", cl_req_rdy, 0);
    chk("refill_mreq_id", mem_req_ID, 1);
    do_reset("mid");
    mem_rsp_val = 1'b1; mem_rsp_ID = 2'd2; mem_rsp_data = 32'h99;
    cl_req_val  = 1'b1; cl_req_addr = 32'h400;
    @(negedge clk);
    chk("stale_err_pre", err_unexp, 0);
    to_drive();
    clr();
    @(negedge clk);
    chk("stale_err",      err_unexp,    1);
    chk("post_mreq_val",  mem_req_val,  1);
    chk("post_mreq_id",   mem_req_ID,   0);
    chk("post_mreq_addr", mem_req_addr, 32'h400);
    chk("post_rsp_val",   cl_rsp_val,   0);
    to_drive();

    // ---------------- randomized run against queue model -------------------
    do_reset("rnd");
    oq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_out[i] = 1'b0; m_done[i] = 1'b0; m_dat[i] = '0;
    end
    m_next = 0;
    m_err  = 1'b0;
    begin
      logic          p_val;
      logic [1:0]    p_id;
      logic [AW-1:0] p_addr;
      p_val = 1'b0; p_id = '0; p_addr = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        int pend [$];
        int r;
        logic hit, byp, e_rdy, e_val, acc;
        logic [DW-1:0] e_data;
        cl_req_val   = ($urandom_range(0, 99) < 60);
        cl_req_addr  = $urandom();
        cl_rsp_rdy   = ($urandom_range(0, 99) < 70);
        mem_rsp_val  = 1'b0;
        mem_rsp_ID   = '0;
        mem_rsp_data = $urandom();
        foreach (oq[j]) if (!m_done[oq[j]]) pend.push_back(oq[j]);
        r = int'($urandom_range(0, 99));
        if (r < 50 && pend.size() > 0) begin
          mem_rsp_val = 1'b1;
          mem_rsp_ID  = IDW'(pend[$urandom_range(0, pend.size() - 1)]);
        end else if (r < 53) begin
          mem_rsp_val = 1'b1;
          mem_rsp_ID  = IDW'($urandom_range(0, DEPTH - 1));
        end
        hit    = mem_rsp_val && m_out[mem_rsp_ID] && !m_done[mem_rsp_ID];
        byp    = BYP && hit && (oq.size() > 0) && (oq[0] == int'(mem_rsp_ID));
        e_rdy  = (oq.size() < DEPTH);
        e_val  = ((oq.size() > 0) && m_done[oq[0]]) || byp;
        e_data = byp ? mem_rsp_data : ((oq.size() > 0) ? m_dat[oq[0]] : '0);
        @(negedge clk);
        chk("rnd_req_rdy",  cl_req_rdy,  e_rdy);
        chk("rnd_rsp_val",  cl_rsp_val,  e_val);
        if (e_val) chk("rnd_rsp_data", cl_rsp_data, e_data);
        chk("rnd_mreq_val", mem_req_val, p_val);
        if (p_val) begin
          chk("rnd_mreq_id",   mem_req_ID,   p_id);
          chk("rnd_mreq_addr", mem_req_addr, p_addr);
        end
        chk("rnd_err", err_unexp, m_err);
        if (mem_rsp_val) begin
          if (hit) begin
            m_done[mem_rsp_ID] = 1'b1;
            m_dat[mem_rsp_ID]  = mem_rsp_data;
          end else begin
            m_err = 1'b1;
          end
        end
        if (e_val && cl_rsp_rdy) begin
          m_out[oq[0]]  = 1'b0;
          m_done[oq[0]] = 1'b0;
          void'(oq.pop_front());
        end
        acc   = cl_req_val && e_rdy;
        p_val = acc;
        if (acc) begin
          p_id   = 2'(m_next);
          p_addr = cl_req_addr;
          oq.push_back(m_next);
          m_out[m_next]  = 1'b1;
          m_done[m_next] = 1'b0;
          m_next = (m_next + 1) % DEPTH;
        end
        to_drive();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
